// File: rtl/sobel_frame_sched_if.sv
// Pixel/result handshake bundle between source, scheduler and Sobel datapath.
// Latency: none, wires only.
// Backpressure: src_ready qualifies src_valid; datapath strobes are unthrottled.
interface sobel_frame_sched_if;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic [7:0] pix_data;
    logic       pix_flag;
    logic       res_flag;
    logic [7:0] res_data;
    logic       out_flag;
    logic [7:0] out_data;

    // Environment side: pixel source plus datapath result producer.
    modport master (
        output src_valid, src_data, res_flag, res_data,
        input  src_ready, pix_data, pix_flag, out_flag, out_data
    );

    // Scheduler side.
    modport slave (
        input  src_valid, src_data, res_flag, res_data,
        output src_ready, pix_data, pix_flag, out_flag, out_data
    );
endinterface

// File: rtl/sobel_frame_sched.sv
// Frame scheduler: meters one frame of pixels into the Sobel datapath and counts results back.
// Latency: pix_flag/pix_data and out_flag/out_data one cycle after the accepting edge; done one cycle after completion.
// Backpressure: src_ready drops during the inter-pixel gap and outside FEED; src_valid low only stalls feeding.
module sobel_frame_sched #(
    parameter int COL_NUM = 100,
    parameter int ROW_NUM = 100,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    sobel_frame_sched_if.slave        bus,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int TOTAL   = COL_NUM * ROW_NUM;
    localparam int EXP     = (COL_NUM - 2) * (ROW_NUM - 2);
    localparam int CNT_LOG = $clog2(TOTAL + 1);
    localparam int CNT_W   = (CNT_LOG > 14) ? CNT_LOG : 14;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [3:0]       GAP_C   = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [CNT_W-1:0]   out_cnt_d;
    logic [3:0]         gap_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               pix_flag_q;
    logic [7:0]         pix_data_q;
    logic               out_flag_q;
    logic [7:0]         out_data_q;
    logic               done_q;
    logic               err_q;
    logic               src_ready_w;
    logic               xfer;
    logic               res_take;

    // Ready is a pure decode of registered state so the source sees no combinational path from its own valid.
    assign src_ready_w = (state_q == S_FEED) && (gap_cnt_q == 4'd0) && (in_cnt_q < TOTAL_C);
    assign xfer        = bus.src_valid && src_ready_w;
    assign res_take    = bus.res_flag && ((state_q == S_FEED) || (state_q == S_DRAIN));

    // Result count including this cycle's strobe; saturates so a chattering datapath can never wrap it.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (res_take && (out_cnt_q != {CNT_W{1'b1}})) begin
            out_cnt_d = out_cnt_q + ONE_C;
        end
    end

    // Frame FSM with counters and all registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            pix_flag_q <= 1'b0;
            pix_data_q <= '0;
            out_flag_q <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pix_flag_q <= xfer;
            if (xfer) begin
                pix_data_q <= bus.src_data;
            end
            out_flag_q <= res_take;
            if (res_take) begin
                out_data_q <= bus.res_data;
            end
            done_q <= 1'b0;
            if (gap_cnt_q != 4'd0) begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FEED;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        gap_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        err_q     <= 1'b0;
                    end
                end
                S_FEED: begin
                    // Results arriving while still feeding are counted but cannot end the frame.
                    out_cnt_q <= out_cnt_d;
                    if (xfer) begin
                        in_cnt_q  <= in_cnt_q + ONE_C;
                        gap_cnt_q <= GAP_C;
                        if (in_cnt_q == LAST_C) begin
                            state_q   <= S_DRAIN;
                            tmo_cnt_q <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    out_cnt_q <= out_cnt_d;
                    if (out_cnt_d >= EXP_C) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (res_take) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q >= TMO_LST) begin
                        // Datapath went silent: give up on the frame and flag it.
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                        err_q     <= 1'b1;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready = src_ready_w;
    assign bus.pix_flag  = pix_flag_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: doc/sobel_frame_sched.md
SOBEL_FRAME_SCHED -- requirements
Module: sobel_frame_sched

Interface
REQ-001 Parameter COL_NUM, default 100, pixels per image row.
REQ-002 Parameter ROW_NUM, default 100, rows per frame.
REQ-003 Parameter GAP, default 2, minimum idle cycles between consecutive pix_flag pulses (1..15).
REQ-004 Parameter TIMEOUT, default 1023, maximum cycles without res_flag allowed in DRAIN.
REQ-005 sys_clk  in  1  clock; all logic on rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 src_valid  in  1  source pixel available.
REQ-009 src_data  in  8  source grey pixel.
REQ-010 src_ready  out  1  scheduler accepts a source pixel this cycle.
REQ-011 pix_data  out  8  pixel to edge-detect datapath.
REQ-012 pix_flag  out  1  one-cycle pixel strobe to datapath.
REQ-013 res_flag  in  1  datapath result strobe.
REQ-014 res_data  in  8  datapath result pixel.
REQ-015 out_flag  out  1  forwarded result strobe.
REQ-016 out_data  out  8  forwarded result pixel.
REQ-017 busy  out  1  high in FEED or DRAIN.
REQ-018 done  out  1  one-cycle frame-complete pulse.
REQ-019 err  out  1  sticky drain-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, FEED, DRAIN, DONE; encoding free.
REQ-021 IDLE -> FEED on start=1; SHALL clear in_cnt, out_cnt, gap_cnt, tmo_cnt and err on that transition.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 src_ready SHALL equal (state==FEED) AND (gap_cnt==0) AND (in_cnt < COL_NUM*ROW_NUM), decoded from registers only.
REQ-024 Transfer = src_valid AND src_ready; on transfer in_cnt increments and gap_cnt loads GAP.
REQ-025 gap_cnt SHALL decrement by 1 each cycle while nonzero.
REQ-026 pix_flag SHALL be 1 exactly one cycle after each transfer, with pix_data = transferred src_data; otherwise pix_flag=0 and pix_data holds.
REQ-027 Consequence: pix_flag pulses spaced >= GAP+1 cycles; src_valid low only delays feeding, never drops data.
REQ-028 FEED -> DRAIN in the cycle after the final (COL_NUM*ROW_NUM-th) transfer.
REQ-029 In FEED and DRAIN, each res_flag=1 SHALL produce out_flag=1 one cycle later with out_data=res_data, and increment out_cnt.
REQ-030 In IDLE and DONE, res_flag SHALL be ignored: out_flag=0, out_cnt unchanged.
REQ-031 Expected results EXP=(COL_NUM-2)*(ROW_NUM-2) (9604 default); counters 14 bits minimum, no wrap.
REQ-032 DRAIN -> DONE when out_cnt reaches EXP (counting the current res_flag).
REQ-033 tmo_cnt SHALL clear on each res_flag and on entering DRAIN, else increment in DRAIN; at TIMEOUT, err<=1 and DRAIN -> DONE.
REQ-034 out_cnt reaching EXP during FEED SHALL NOT end the frame; completion checked only in DRAIN.
REQ-035 DONE lasts one cycle, asserts done=1, then -> IDLE; err holds until next accepted start.
REQ-036 busy SHALL be registered-state decoded, high exactly in FEED and DRAIN.

Reset
REQ-037 On sys_rst_n=0: state IDLE; src_ready, pix_flag, out_flag, done, busy, err = 0; pix_data, out_data = 0; all counters 0.
REQ-038 Reset mid-frame SHALL abort immediately; no done pulse follows reset release.

Verification
REQ-039 start, src_valid=1 constant, datapath model echoing results -> 10000 pix_flag pulses spaced exactly 3 cycles, 9604 out_flag, single done, err=0.
REQ-040 src_valid toggled randomly -> pix_data sequence equals src_data accepted sequence, no loss or duplication, spacing >= 3.
REQ-041 Datapath model stops after 9000 results -> err=1 and done 1023 cycles after last res_flag, state IDLE after.
REQ-042 start pulsed during FEED -> counters unaffected; second start after done -> err cleared, new frame runs.
REQ-043 res_flag while IDLE -> out_flag stays 0.
REQ-044 sys_rst_n low at in_cnt=5000 -> all outputs 0 next cycle; after release, idle until start.
